// File: rtl/operator_sched.sv
// operator_sched: round-robin scheduler sharing one operator datapath among NUM_REQ requesters
// Ports: clk, rst_n (synchronous, active-low)
//   requests  : req_valid, req_ready (one-hot grant), req_op, req_a, req_b, req_c (flattened per slot)
//   responses : rsp_valid, rsp_ready, rsp_id, rsp_z
//   operator  : op_reg_wr, op_reg_addr, op_reg_wr_data, op_a, op_b, op_c, op_z
// Macro OPERATOR_SCHED_CFG_SKIP_EN: skip the op-type register write when the op is unchanged.
module operator_sched #(
  parameter int NUM_REQ = 4,
  parameter int OP_LAT = 4,
  parameter int OP_REG_ADDR = 10,
  parameter int OP_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*32-1:0]     req_a,
  input  logic [NUM_REQ*32-1:0]     req_b,
  input  logic [NUM_REQ*32-1:0]     req_c,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [63:0]               rsp_z,
  output logic                      op_reg_wr,
  output logic [31:0]               op_reg_addr,
  output logic [31:0]               op_reg_wr_data,
  output logic [31:0]               op_a,
  output logic [31:0]               op_b,
  output logic [31:0]               op_c,
  input  logic [63:0]               op_z
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int LW = OP_LAT > 1 ? $clog2(OP_LAT) : 1;
  typedef enum logic [2:0] {IDLE, CFG, CFG_WAIT, EXEC, RESP} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, gnt_idx;
  logic [OP_W-1:0] op_q, op_d, cur_op_q, cur_op_d, gnt_op;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [63:0] z_q, z_d;
  logic [LW-1:0] lat_q, lat_d;
  logic gnt_found, skip;
  int j;
  // Highest k is visited first so the smallest offset from rr_ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end
  assign gnt_op = req_op[gnt_idx*OP_W +: OP_W];
`ifdef OPERATOR_SCHED_CFG_SKIP_EN
  assign skip = (gnt_op == cur_op_q) && (cur_op_q != '0);
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d = id_q;
    op_d = op_q;
    cur_op_d = cur_op_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    z_d = z_q;
    lat_d = lat_q;
    req_ready = '0;
    case (state_q)
      // A grant shown while rst_n is low would be wiped by the reset edge, so none is offered.
      IDLE: if (gnt_found && rst_n) begin
        req_ready[gnt_idx] = 1'b1;
        id_d = gnt_idx;
        op_d = gnt_op;
        a_d = req_a[gnt_idx*32 +: 32];
        b_d = req_b[gnt_idx*32 +: 32];
        c_d = req_c[gnt_idx*32 +: 32];
        rr_ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        lat_d = LW'(OP_LAT - 1);
        state_d = skip ? EXEC : CFG;
      end
      CFG: begin
        cur_op_d = op_q;
        state_d = CFG_WAIT;
      end
      CFG_WAIT: begin
        lat_d = LW'(OP_LAT - 1);
        state_d = EXEC;
      end
      EXEC: begin
        z_d = (lat_q == '0) ? op_z : z_q;
        state_d = (lat_q == '0) ? RESP : EXEC;
        lat_d = (lat_q == '0) ? lat_q : lat_q - 1'b1;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      id_q <= '0;
      op_q <= '0;
      cur_op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      z_q <= '0;
      lat_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q <= id_d;
      op_q <= op_d;
      cur_op_q <= cur_op_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      z_q <= z_d;
      lat_q <= lat_d;
    end
  end
  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_z = z_q;
  assign op_reg_wr = state_q == CFG;
  assign op_reg_addr = op_reg_wr ? 32'(OP_REG_ADDR) : '0;
  assign op_reg_wr_data = op_reg_wr ? 32'(op_q) : '0;
  assign op_a = a_q;
  assign op_b = b_q;
  assign op_c = c_q;
endmodule

// File: tb/tb_operator_sched.sv
// tb_operator_sched: directed bench for operator_sched with a small operator model
module tb_operator_sched;
  localparam int N = 4;
  localparam int LAT = 4;
`ifdef OPERATOR_SCHED_CFG_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*2-1:0] req_op = '0;
  logic [N*32-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [63:0] rsp_z, op_z;
  logic op_reg_wr;
  logic [31:0] op_reg_addr, op_reg_wr_data, op_a, op_b, op_c;
  int cyc = 0, wr_cnt = 0, n_vec = 0, n_err = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [1:0] opreg = '0;
  int gid[8], gcyc[8], rid[8], rcyc[8];
  logic [63:0] rz[8];
  operator_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .op_reg_wr(op_reg_wr), .op_reg_addr(op_reg_addr), .op_reg_wr_data(op_reg_wr_data),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_z(op_z)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (op_reg_wr) begin
      wr_cnt <= wr_cnt + 1;
      wr_addr <= op_reg_addr;
      wr_data <= op_reg_wr_data;
      if (op_reg_addr == 32'd10) opreg <= op_reg_wr_data[1:0];
    end
  end
  always_comb begin
    op_z = '0;
    case (opreg)
      2'd1: op_z = {32'b0, op_a} + {32'b0, op_b} - {32'b0, op_c};
      2'd2: op_z = {32'b0, op_a} - {32'b0, op_b} - {32'b0, op_c};
      2'd3: op_z = {32'b0, op_a} * {32'b0, op_b} + {32'b0, op_c};
      default: op_z = '0;
    endcase
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_req(input int id, input logic [1:0] op, input logic [31:0] a, b, c);
    req_op[id*2 +: 2] = op;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_c[id*32 +: 32] = c;
  endtask
  task automatic zero_chk(input string tag);
    chk({tag, "_ctl"}, {rsp_valid, op_reg_wr, req_ready, rsp_id}, 0);
    chk({tag, "_z"}, rsp_z, 0);
    chk({tag, "_reg"}, {op_reg_addr, op_reg_wr_data}, 0);
    chk({tag, "_ab"}, {op_a, op_b}, 0);
    chk({tag, "_c"}, op_c, 0);
  endtask
  task automatic do_reset(input string tag);
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    zero_chk(tag);
    rst_n = 1'b1;
  endtask
  task automatic collect(input logic [N-1:0] m, input int n);
    logic [N-1:0] gm;
    int ng, nr;
    ng = 0;
    nr = 0;
    @(posedge clk);
    #1 req_valid = req_valid | m;
    for (int t = 0; t < 400 && (ng < n || nr < n); t++) begin
      @(negedge clk);
      gm = req_ready;
      for (int i = 0; i < N; i++) if (gm[i] && ng < 8) begin gid[ng] = i; gcyc[ng] = cyc; ng++; end
      if (rsp_valid && rsp_ready && nr < 8) begin rid[nr] = rsp_id; rz[nr] = rsp_z; rcyc[nr] = cyc; nr++; end
      @(posedge clk);
      #1 req_valid = req_valid & ~gm;
    end
    chk("collect_done", ng + nr, 2 * n);
  endtask
  task automatic grant(input int id, output int g);
    g = -1;
    @(posedge clk);
    #1 req_valid[id] = 1'b1;
    for (int t = 0; t < 100 && g < 0; t++) begin
      @(negedge clk);
      if (req_ready[id]) g = cyc;
    end
    chk("grant_seen", g >= 0, 1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask
  task automatic wait_rsp();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    chk("rsp_seen", seen, 1);
  endtask
  initial begin
    int w0, g, hits;
    do_reset("rst");
    set_req(0, 2'd1, 100, 50, 10);
    w0 = wr_cnt;
    collect(4'b0001, 1);
    chk("t1_z", rz[0], 140);
    chk("t1_id", rid[0], 0);
    chk("t1_lat", rcyc[0] - gcyc[0], LAT + 3);
    chk("t1_wr", wr_cnt - w0, 1);
    chk("t1_addr", wr_addr, 10);
    chk("t1_data", wr_data, 1);
    set_req(0, 2'd2, 100, 50, 10);
    w0 = wr_cnt;
    collect(4'b0001, 1);
    chk("t2_z", rz[0], 40);
    chk("t2_wr", wr_cnt - w0, 1);
    chk("t2_data", wr_data, 2);
    chk("t2_lat", rcyc[0] - gcyc[0], LAT + 3);
    w0 = wr_cnt;
    collect(4'b0001, 1);
    chk("skip_z", rz[0], 40);
    chk("skip_wr", wr_cnt - w0, SKIP ? 0 : 1);
    chk("skip_lat", rcyc[0] - gcyc[0], SKIP ? LAT + 1 : LAT + 3);
    do_reset("rst2");
    for (int i = 0; i < N; i++) set_req(i, 2'd1, i, 100, 0);
    w0 = wr_cnt;
    collect(4'b1111, 4);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rr_gnt%0d", k), gid[k], k);
      chk($sformatf("rr_id%0d", k), rid[k], k);
      chk($sformatf("rr_z%0d", k), rz[k], 100 + k);
    end
    chk("rr_wr", wr_cnt - w0, SKIP ? 1 : 4);
    set_req(0, 2'd1, 100, 50, 10);
    collect(4'b0001, 1);
    set_req(2, 2'd1, 5, 6, 1);
    collect(4'b0101, 2);
    chk("rr2_first", gid[0], 2);
    chk("rr2_second", gid[1], 0);
    chk("rr2_z0", rz[0], 10);
    chk("rr2_z1", rz[1], 140);
    rsp_ready = 1'b0;
    set_req(1, 2'd1, 7, 8, 5);
    set_req(3, 2'd3, 6, 7, 0);
    grant(1, g);
    req_valid[3] = 1'b1;
    wait_rsp();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_z", rsp_z, 10);
      chk("bp_id", rsp_id, 1);
      chk("bp_rdy", req_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_acc_rdy", req_ready, 0);
    @(negedge clk);
    chk("bp_gnt", req_ready, 4'b1000);
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    wait_rsp();
    chk("bp3_z", rsp_z, 42);
    chk("bp3_id", rsp_id, 3);
    set_req(1, 2'd1, 1, 2, 3);
    grant(1, g);
    @(posedge clk);
    do_reset("mid_rst");
    hits = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (rsp_valid) hits++;
    end
    chk("mid_norsp", hits, 0);
    set_req(1, 2'd1, 9, 9, 9);
    w0 = wr_cnt;
    collect(4'b0010, 1);
    chk("mid_wr", wr_cnt - w0, 1);
    chk("mid_lat", rcyc[0] - gcyc[0], LAT + 3);
    chk("mid_z", rz[0], 9);
    chk("mid_id", rid[0], 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
